// File: rtl/reg_file_pkg.sv
// Shared defaults for the multi-port register file: widths, the PC alias
// index and the offset applied when the PC alias is read.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 3;
  localparam int DEF_PC_IDX = 15;
  localparam int DEF_PC_OFS = 8;

  // Value returned by a read of the PC alias in the default configuration.
  function automatic logic [DEF_DATA_W-1:0] pc_read_value(input logic [DEF_DATA_W-1:0] pc);
    return pc + DEF_DATA_W'(DEF_PC_OFS);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between decode/writeback and the register file. The master
// side drives addresses, write triples and the fetch PC; the slave side
// (the register file) returns read data, the PC export and the conflict flag.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en0;
  logic [ADDR_W-1:0]        wr_addr0;
  logic [DATA_W-1:0]        wr_data0;
  logic                     wr_en1;
  logic [ADDR_W-1:0]        wr_addr1;
  logic [DATA_W-1:0]        wr_data1;
  logic [DATA_W-1:0]        pc_in;
  logic                     pc_wr_valid;
  logic [DATA_W-1:0]        pc_wr_data;
  logic                     wr_conflict;

  modport master (
    output rd_en, rd_addr, wr_en0, wr_addr0, wr_data0,
           wr_en1, wr_addr1, wr_data1, pc_in,
    input  rd_data, pc_wr_valid, pc_wr_data, wr_conflict
  );

  modport slave (
    input  rd_en, rd_addr, wr_en0, wr_addr0, wr_data0,
           wr_en1, wr_addr1, wr_data1, pc_in,
    output rd_data, pc_wr_valid, pc_wr_data, wr_conflict
  );

endinterface

// File: rtl/reg_file_fwd.sv
// Per-read-port operand selection: PC alias first, then same-cycle
// forwarding from write port 1 (priority), then write port 0, then the
// stored word. Purely combinational.
module reg_file_fwd
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int PC_OFS = DEF_PC_OFS
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] arr_word,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] eff
);

  // Pick the effective operand; the PC alias is never forwarded from writes.
  always_comb begin
    eff = arr_word;
    if (rd_addr == ADDR_W'(PC_IDX)) begin
      eff = pc_in + DATA_W'(PC_OFS);
    end else if (wr_en1 && (wr_addr1 == rd_addr)) begin
      eff = wr_data1;
    end else if (wr_en0 && (wr_addr0 == rd_addr)) begin
      eff = wr_data0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two clocked write ports (port 1 wins on a
// collision), NUM_RD forwarded read ports with optional output registers,
// and a PC alias whose writes are exported as a branch request.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int READ_REG = 1,
  parameter int PC_IDX   = DEF_PC_IDX,
  parameter int PC_OFS   = DEF_PC_OFS
) (
  input logic         clk,
  input logic         rst,
  reg_file_mp_if.slave bus
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_int;
  logic                     pc_valid_q;
  logic [DATA_W-1:0]        pc_data_q;
  logic                     conflict_q;

  logic pc_hit0;
  logic pc_hit1;

  assign pc_hit0 = bus.wr_en0 && (bus.wr_addr0 == ADDR_W'(PC_IDX));
  assign pc_hit1 = bus.wr_en1 && (bus.wr_addr1 == ADDR_W'(PC_IDX));

  // Storage update; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.wr_en0 && !pc_hit0) begin
        mem[bus.wr_addr0] <= bus.wr_data0;
      end
      if (bus.wr_en1 && !pc_hit1) begin
        mem[bus.wr_addr1] <= bus.wr_data1;
      end
    end
  end

  // PC-write export and collision flag, each a one-cycle pulse; the PC data holds until the next PC write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_valid_q <= 1'b0;
      pc_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      pc_valid_q <= pc_hit0 || pc_hit1;
      if (pc_hit1) begin
        pc_data_q <= bus.wr_data1;
      end else if (pc_hit0) begin
        pc_data_q <= bus.wr_data0;
      end
      conflict_q <= bus.wr_en0 && bus.wr_en1 && (bus.wr_addr0 == bus.wr_addr1);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] eff;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    reg_file_fwd #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PC_IDX (PC_IDX),
      .PC_OFS (PC_OFS)
    ) u_fwd (
      .rd_addr  (addr),
      .wr_en0   (bus.wr_en0),
      .wr_addr0 (bus.wr_addr0),
      .wr_data0 (bus.wr_data0),
      .wr_en1   (bus.wr_en1),
      .wr_addr1 (bus.wr_addr1),
      .wr_data1 (bus.wr_data1),
      .arr_word (mem[addr]),
      .pc_in    (bus.pc_in),
      .eff      (eff)
    );

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] q;

      // Registered read: capture the forwarded operand when enabled, otherwise hold.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (bus.rd_en[k]) begin
          q <= eff;
        end
      end

      assign rd_data_int[k*DATA_W +: DATA_W] = q;
    end else begin : g_comb
      assign rd_data_int[k*DATA_W +: DATA_W] = bus.rd_en[k] ? eff : '0;
    end
  end

  assign bus.rd_data     = rd_data_int;
  assign bus.pc_wr_valid = pc_valid_q;
  assign bus.pc_wr_data  = pc_data_q;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: one registered-read and one combinational-read
// instance share identical stimulus and are compared against a reference
// model built from the register file's behavioural rules.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NR-1:0]    s_rd_en;
  logic [NR*AW-1:0] s_rd_addr;
  logic             s_we0, s_we1;
  logic [AW-1:0]    s_wa0, s_wa1;
  logic [DW-1:0]    s_wd0, s_wd1;
  logic [DW-1:0]    s_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [16];
  logic [DW-1:0] m_rq  [NR];
  logic          m_pc_valid;
  logic [DW-1:0] m_pc_data;
  logic          m_conf;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_r ();
  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_c ();

  assign bus_r.rd_en = s_rd_en;   assign bus_c.rd_en = s_rd_en;
  assign bus_r.rd_addr = s_rd_addr; assign bus_c.rd_addr = s_rd_addr;
  assign bus_r.wr_en0 = s_we0;    assign bus_c.wr_en0 = s_we0;
  assign bus_r.wr_addr0 = s_wa0;  assign bus_c.wr_addr0 = s_wa0;
  assign bus_r.wr_data0 = s_wd0;  assign bus_c.wr_data0 = s_wd0;
  assign bus_r.wr_en1 = s_we1;    assign bus_c.wr_en1 = s_we1;
  assign bus_r.wr_addr1 = s_wa1;  assign bus_c.wr_addr1 = s_wa1;
  assign bus_r.wr_data1 = s_wd1;  assign bus_c.wr_data1 = s_wd1;
  assign bus_r.pc_in = s_pc;      assign bus_c.pc_in = s_pc;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .READ_REG(1), .PC_IDX(15), .PC_OFS(8))
    u_reg (.clk(clk), .rst(rst), .bus(bus_r));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .READ_REG(0), .PC_IDX(15), .PC_OFS(8))
    u_comb (.clk(clk), .rst(rst), .bus(bus_c));

  always #5 clk = ~clk;

  // Hard stop in case a task never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout got running exp finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] rd_r(input int k);
    return bus_r.rd_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd_c(input int k);
    return bus_c.rd_data[k*DW +: DW];
  endfunction

  // What a read of port k should see this cycle.
  function automatic logic [DW-1:0] m_eff(input int k);
    logic [AW-1:0] a;
    a = s_rd_addr[k*AW +: AW];
    if (a == 4'd15) return s_pc + 32'd8;
    if (s_we1 && s_wa1 == a) return s_wd1;
    if (s_we0 && s_wa0 == a) return s_wd0;
    return m_mem[a];
  endfunction

  function automatic logic [DW-1:0] m_comb(input int k);
    return s_rd_en[k] ? m_eff(k) : 32'd0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    for (int k = 0; k < NR; k++) m_rq[k] = '0;
    m_pc_valid = 1'b0;
    m_pc_data  = '0;
    m_conf     = 1'b0;
  endtask

  task automatic clear_inputs();
    s_rd_en = '0; s_rd_addr = '0;
    s_we0 = 0; s_wa0 = '0; s_wd0 = '0;
    s_we1 = 0; s_wa1 = '0; s_wd1 = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    s_rd_en[k] = 1'b1;
    s_rd_addr[k*AW +: AW] = a;
  endtask

  // Advance one clock and move the model by the same edge; returns 1 after the edge.
  task automatic tick();
    logic [DW-1:0] eff [NR];
    logic          pc0, pc1;
    for (int k = 0; k < NR; k++) eff[k] = m_eff(k);
    pc0 = s_we0 && s_wa0 == 4'd15;
    pc1 = s_we1 && s_wa1 == 4'd15;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < NR; k++) if (s_rd_en[k]) m_rq[k] = eff[k];
      m_conf     = s_we0 && s_we1 && (s_wa0 == s_wa1);
      m_pc_valid = pc0 || pc1;
      if (pc1) m_pc_data = s_wd1;
      else if (pc0) m_pc_data = s_wd0;
      if (s_we0 && !pc0) m_mem[s_wa0] = s_wd0;
      if (s_we1 && !pc1) m_mem[s_wa1] = s_wd1;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    s_we0 = 1; s_wa0 = 4'd3; s_wd0 = 32'hDEADBEEF;
    tick();
    clear_inputs();
    set_rd(0, 4'd3);
    s_we0 = 1; s_wa0 = 4'd15; s_wd0 = 32'h1111_1111;
    s_we1 = 1; s_wa1 = 4'd15; s_wd1 = 32'h2222_2222;
    tick();
    checks++;
    if (rd_r(0) !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL pre_reset_rd got %h exp %h", rd_r(0), 32'hDEADBEEF); end
    checks++;
    if (bus_r.pc_wr_valid !== 1'b1 || bus_r.pc_wr_data !== 32'h2222_2222) begin
      errors++; $display("[TB] FAIL pre_reset_pc got %b/%h exp 1/%h", bus_r.pc_wr_valid, bus_r.pc_wr_data, 32'h2222_2222);
    end
    checks++;
    if (bus_r.wr_conflict !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_conflict got %b exp 1", bus_r.wr_conflict); end
    // Asynchronous assertion in the middle of the cycle
    clear_inputs();
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (bus_r.rd_data !== '0) begin errors++; $display("[TB] FAIL async_rst_rd got %h exp 0", bus_r.rd_data); end
    checks++;
    if (bus_r.pc_wr_valid !== 1'b0 || bus_r.pc_wr_data !== '0) begin
      errors++; $display("[TB] FAIL async_rst_pc got %b/%h exp 0/0", bus_r.pc_wr_valid, bus_r.pc_wr_data);
    end
    checks++;
    if (bus_r.wr_conflict !== 1'b0 || bus_c.wr_conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL async_rst_conflict got %b/%b exp 0/0", bus_r.wr_conflict, bus_c.wr_conflict);
    end
    // Writes attempted while reset is held must not land
    s_we0 = 1; s_wa0 = 4'd3; s_wd0 = 32'h1234_5678;
    tick();
    tick();
    #2;
    rst = 1'b0;
    clear_inputs();
    set_rd(0, 4'd3);
    #1;
    checks++;
    if (rd_c(0) !== 32'd0) begin errors++; $display("[TB] FAIL post_rst_comb_r3 got %h exp 0", rd_c(0)); end
    tick();
    checks++;
    if (rd_r(0) !== 32'd0) begin errors++; $display("[TB] FAIL post_rst_reg_r3 got %h exp 0", rd_r(0)); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] want [NR];
    want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd4;
    clear_inputs();
    s_we0 = 1; s_wa0 = 4'd1; s_wd0 = 32'd1; tick();
    s_wa0 = 4'd2; s_wd0 = 32'd2; tick();
    s_wa0 = 4'd4; s_wd0 = 32'd4; tick();
    clear_inputs();
    set_rd(0, 4'd1); set_rd(1, 4'd2); set_rd(2, 4'd4);
    tick();
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (rd_r(k) !== want[k]) begin errors++; $display("[TB] FAIL basic_rd%0d got %h exp %h", k, rd_r(k), want[k]); end
    end
    // Port 2 disabled while r4 is rewritten: it must hold the old value
    s_rd_en[2] = 1'b0;
    s_we0 = 1; s_wa0 = 4'd4; s_wd0 = 32'd9;
    tick();
    checks++;
    if (rd_r(2) !== 32'd4) begin errors++; $display("[TB] FAIL hold_rd2 got %h exp 4", rd_r(2)); end
    clear_inputs();
    set_rd(2, 4'd4);
    tick();
    checks++;
    if (rd_r(2) !== 32'd9) begin errors++; $display("[TB] FAIL reread_r4 got %h exp 9", rd_r(2)); end
  endtask

  task automatic test_forward();
    clear_inputs();
    s_we0 = 1; s_wa0 = 4'd5; s_wd0 = 32'h55;
    set_rd(0, 4'd5);
    #1;
    checks++;
    if (rd_c(0) !== 32'h55) begin errors++; $display("[TB] FAIL fwd_comb got %h exp %h", rd_c(0), 32'h55); end
    tick();
    checks++;
    if (rd_r(0) !== 32'h55) begin errors++; $display("[TB] FAIL fwd_reg got %h exp %h", rd_r(0), 32'h55); end
  endtask

  task automatic test_collision();
    clear_inputs();
    s_we0 = 1; s_wa0 = 4'd6; s_wd0 = 32'h11;
    s_we1 = 1; s_wa1 = 4'd6; s_wd1 = 32'h22;
    set_rd(1, 4'd6);
    #1;
    checks++;
    if (rd_c(1) !== 32'h22) begin errors++; $display("[TB] FAIL coll_fwd got %h exp %h", rd_c(1), 32'h22); end
    tick();
    checks++;
    if (bus_r.wr_conflict !== 1'b1) begin errors++; $display("[TB] FAIL coll_flag got %b exp 1", bus_r.wr_conflict); end
    clear_inputs();
    set_rd(0, 4'd6);
    tick();
    checks++;
    if (rd_r(0) !== 32'h22) begin errors++; $display("[TB] FAIL coll_store got %h exp %h", rd_r(0), 32'h22); end
    checks++;
    if (bus_r.wr_conflict !== 1'b0) begin errors++; $display("[TB] FAIL coll_pulse_len got %b exp 0", bus_r.wr_conflict); end
    // Different addresses: both land, no flag
    clear_inputs();
    s_we0 = 1; s_wa0 = 4'd6; s_wd0 = 32'h66;
    s_we1 = 1; s_wa1 = 4'd7; s_wd1 = 32'h77;
    tick();
    checks++;
    if (bus_r.wr_conflict !== 1'b0) begin errors++; $display("[TB] FAIL nocoll_flag got %b exp 0", bus_r.wr_conflict); end
    clear_inputs();
    set_rd(0, 4'd6); set_rd(1, 4'd7);
    tick();
    checks++;
    if (rd_r(0) !== 32'h66 || rd_r(1) !== 32'h77) begin
      errors++; $display("[TB] FAIL nocoll_store got %h/%h exp 66/77", rd_r(0), rd_r(1));
    end
  endtask

  task automatic test_pc();
    clear_inputs();
    s_pc = 32'h100;
    set_rd(0, 4'd15);
    #1;
    checks++;
    if (rd_c(0) !== 32'h108) begin errors++; $display("[TB] FAIL pc_read_comb got %h exp %h", rd_c(0), 32'h108); end
    tick();
    checks++;
    if (rd_r(0) !== 32'h108) begin errors++; $display("[TB] FAIL pc_read_reg got %h exp %h", rd_r(0), 32'h108); end
    clear_inputs();
    s_we0 = 1; s_wa0 = 4'd15; s_wd0 = 32'h200;
    tick();
    checks++;
    if (bus_r.pc_wr_valid !== 1'b1 || bus_r.pc_wr_data !== 32'h200) begin
      errors++; $display("[TB] FAIL pc_export got %b/%h exp 1/%h", bus_r.pc_wr_valid, bus_r.pc_wr_data, 32'h200);
    end
    checks++;
    if (bus_r.wr_conflict !== 1'b0) begin errors++; $display("[TB] FAIL pc_single_conflict got %b exp 0", bus_r.wr_conflict); end
    clear_inputs();
    set_rd(1, 4'd15);
    tick();
    checks++;
    if (bus_r.pc_wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL pc_pulse_len got %b exp 0", bus_r.pc_wr_valid); end
    checks++;
    if (rd_r(1) !== 32'h108) begin errors++; $display("[TB] FAIL pc_not_stored got %h exp %h", rd_r(1), 32'h108); end
    clear_inputs();
    s_pc = 32'hFFFF_FFFC;
    set_rd(2, 4'd15);
    tick();
    checks++;
    if (rd_r(2) !== 32'h4) begin errors++; $display("[TB] FAIL pc_wrap got %h exp 4", rd_r(2)); end
    s_pc = 32'h1000;
  endtask

  task automatic test_multi_port();
    clear_inputs();
    s_we1 = 1; s_wa1 = 4'd2; s_wd1 = 32'hA5A5_A5A5;
    tick();
    clear_inputs();
    for (int k = 0; k < NR; k++) set_rd(k, 4'd2);
    tick();
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (rd_r(k) !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL multi_rd%0d got %h exp %h", k, rd_r(k), 32'hA5A5_A5A5); end
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 4) == 0) return 4'd15;
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NR; k++) s_rd_addr[k*AW +: AW] = pick_addr();
      s_rd_en = NR'($urandom);
      s_we0 = 1'($urandom); s_wa0 = pick_addr(); s_wd0 = $urandom;
      s_we1 = 1'($urandom); s_wa1 = pick_addr(); s_wd1 = $urandom;
      s_pc = $urandom;
      #1;
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (rd_c(k) !== m_comb(k)) begin errors++; $display("[TB] FAIL rand_comb_rd%0d cyc %0d got %h exp %h", k, n, rd_c(k), m_comb(k)); end
      end
      tick();
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (rd_r(k) !== m_rq[k]) begin errors++; $display("[TB] FAIL rand_reg_rd%0d cyc %0d got %h exp %h", k, n, rd_r(k), m_rq[k]); end
      end
      checks++;
      if (bus_r.wr_conflict !== m_conf || bus_c.wr_conflict !== m_conf) begin
        errors++; $display("[TB] FAIL rand_conflict cyc %0d got %b/%b exp %b", n, bus_r.wr_conflict, bus_c.wr_conflict, m_conf);
      end
      checks++;
      if (bus_r.pc_wr_valid !== m_pc_valid || bus_c.pc_wr_valid !== m_pc_valid) begin
        errors++; $display("[TB] FAIL rand_pc_valid cyc %0d got %b/%b exp %b", n, bus_r.pc_wr_valid, bus_c.pc_wr_valid, m_pc_valid);
      end
      if (m_pc_valid) begin
        checks++;
        if (bus_r.pc_wr_data !== m_pc_data) begin errors++; $display("[TB] FAIL rand_pc_data cyc %0d got %h exp %h", n, bus_r.pc_wr_data, m_pc_data); end
      end
    end
  endtask

  initial begin
    clear_inputs();
    s_pc = 32'h1000;
    model_clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_r.rd_data !== '0 || bus_r.pc_wr_valid !== 1'b0 || bus_r.wr_conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state got %h/%b/%b exp 0/0/0", bus_r.rd_data, bus_r.pc_wr_valid, bus_r.wr_conflict);
    end
    rst = 1'b0;
    $display("[TB] starting scenarios");
    test_reset();
    test_basic();
    test_forward();
    test_collision();
    test_pc();
    test_multi_port();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the CPU datapath; successor to the single-read-pair, level-sensitive register file.
- Adds:
  - N read ports with per-port enable and optional registered output.
  - Two clocked write ports (ALU result + base-register writeback).
  - Same-cycle write-to-read forwarding.
  - Write-port collision flag.
  - PC-index redirect: reads return pc_in + offset; writes are exported as a branch request instead of stored.
- Sits between decode (addresses) and execute (operands); the writeback stage drives the write ports.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 3, number of read ports (1..4)
- READ_REG, 1, 1 = read data registered at posedge; 0 = combinational read
- PC_IDX, 15, index treated as program counter
- PC_OFS, 8, value added to pc_in when PC_IDX is read

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
- wr_en0  in  1  write port 0 enable
- wr_addr0  in  ADDR_W  write port 0 address
- wr_data0  in  DATA_W  write port 0 data
- wr_en1  in  1  write port 1 enable (priority port)
- wr_addr1  in  ADDR_W  write port 1 address
- wr_data1  in  DATA_W  write port 1 data
- pc_in  in  DATA_W  current fetch PC
- pc_wr_valid  out  1  one-cycle pulse: a write targeted PC_IDX
- pc_wr_data  out  DATA_W  data of that PC write
- wr_conflict  out  1  one-cycle pulse: both write ports enabled to the same address

Behaviour:
- Reset (async, rst=1): all NUM_REGS entries = 0, rd_data = 0, pc_wr_valid = 0, pc_wr_data = 0, wr_conflict = 0. Held while rst=1; no write takes effect during reset.
- Writes:
  - Committed at posedge when wr_enX=1 and wr_addrX != PC_IDX.
  - Both enabled to the same address: port 1 data stored; wr_conflict=1 in the following cycle, else 0.
  - Different addresses: both stored in the same edge.
- PC writes:
  - A write to PC_IDX never modifies the array.
  - pc_wr_valid=1 and pc_wr_data set at the next posedge, for exactly one cycle.
  - If both ports write PC_IDX, port 1 data is exported and wr_conflict also pulses.
- Effective read value for port k (eff_k):
  - If rd_addr_k == PC_IDX: pc_in + PC_OFS, modulo 2**DATA_W.
  - Else if wr_en1 && wr_addr1 == rd_addr_k: wr_data1.
  - Else if wr_en0 && wr_addr0 == rd_addr_k: wr_data0.
  - Else: array[rd_addr_k].
  - Forwarding uses the current-cycle write inputs.
- READ_REG=1:
  - At posedge, rd_data_k <= eff_k when rd_en_k=1; holds previous value when rd_en_k=0.
  - Latency 1 cycle. A read issued in the same cycle as a write to that address returns the new data.
- READ_REG=0:
  - rd_data_k = eff_k when rd_en_k=1, else 0 (combinational).
  - Latency 0. Write-through visible in the same cycle.
- No read port blocks another; all NUM_RD ports may address the same register.
- Reset deasserting mid-stream: the first posedge after deassert behaves as normal operation on an all-zero array.

Decomposition:
- Package reg_file_pkg: default DATA_W/ADDR_W constants, PC_IDX and PC_OFS defaults, and a function pc_read_value(pc) returning pc + PC_OFS.
- Sub-module reg_file_fwd: one instance per read port. Takes rd_addr, both write port triples, the array word and pc_in; outputs eff. It is purely combinational and unit-testable on its own.
- Top level holds: storage array, write logic, PC export and conflict registers, and the generate loop of reg_file_fwd plus the optional output registers.

Test Plan:
- Reset: write 0xDEADBEEF to r3, assert rst asynchronously mid-cycle -> rd_data, pc_wr_valid and wr_conflict go to 0 immediately; reading r3 after release returns 0.
- Basic write/read (READ_REG=1): write r1=1, r2=2, r4=4 on successive cycles; read ports 0/1/2 = r1/r2/r4 -> values 1, 2, 4 one cycle after the read. rd_en=0 on port 2 -> port 2 holds 4 while r4 is rewritten to 9.
- Forwarding: same cycle wr_en0 r5=0x55 and port 0 reads r5 -> registered rd_data0 = 0x55. Repeat with READ_REG=0 -> 0x55 visible combinationally in the same cycle.
- Collision: wr_en0 r6=0x11 and wr_en1 r6=0x22 in the same cycle -> r6 reads 0x22; wr_conflict=1 for exactly the next cycle. Ports to r6 and r7 -> both stored, wr_conflict=0.
- PC redirect:
  - pc_in=0x100, read r15 -> 0x108.
  - Write r15=0x200 via port 0 -> pc_wr_valid=1 and pc_wr_data=0x200 for one cycle; a subsequent read of r15 still returns pc_in+8.
  - pc_in=0xFFFFFFFC, read r15 -> 0x00000004 (wrap-around).
- Multi-port same-address: all three ports read r2=0xA5A5A5A5 simultaneously -> all three return 0xA5A5A5A5.
